// File: rtl/dsp_add_arbiter_if.sv
// Request/response bundle between the sail-core requesters and the shared adder arbiter.
// Requester i packs its operands into bits [32i+31:32i] of req_a/req_b.
interface dsp_add_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*32-1:0] req_a;
   logic [NUM_REQ*32-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_data;
   logic [ID_W-1:0]       rsp_id;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/dsp_add_arbiter.sv
// Round-robin arbiter sharing one external 32-bit DSP adder between NUM_REQ requesters.
// One operation in flight at a time: IDLE -> CALC (ADD_LATENCY cycles) -> RESP.
module dsp_add_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int ADD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   dsp_add_arbiter_if.slave        bus,
   output logic                    busy,
   output logic [31:0]             add_a,
   output logic [31:0]             add_b,
   input  logic [31:0]             add_sum
);
   localparam int CNT_W = 2;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t           state;
   logic [ID_W-1:0]  rr_ptr;
   logic [CNT_W-1:0] lat_cnt;

   logic             gnt_found;
   logic [ID_W-1:0]  gnt_idx;
   logic [31:0]      gnt_a;
   logic [31:0]      gnt_b;

   // Search order starts at rr_ptr and wraps; the first valid requester wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && bus.req_valid[i] && (i == (int'(rr_ptr) + k) % NUM_REQ)) begin
               gnt_found = 1'b1;
               gnt_idx   = ID_W'(i);
            end
         end
      end
      gnt_a = '0;
      gnt_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            gnt_a = bus.req_a[32*i +: 32];
            gnt_b = bus.req_b[32*i +: 32];
         end
      end
   end

   // Grant is visible only while IDLE and never while reset is held.
   always_comb begin
      bus.req_ready = '0;
      if (state == IDLE && gnt_found && !reset)
         bus.req_ready = NUM_REQ'(1) << gnt_idx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         lat_cnt       <= '0;
         add_a         <= '0;
         add_b         <= '0;
         bus.rsp_data  <= '0;
         bus.rsp_id    <= '0;
         bus.rsp_valid <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state)
            // operand stage: granted operands registered onto the adder inputs
            IDLE: begin
               if (gnt_found) begin
                  add_a      <= gnt_a;
                  add_b      <= gnt_b;
                  bus.rsp_id <= gnt_idx;
                  lat_cnt    <= CNT_W'(ADD_LATENCY - 1);
                  busy       <= 1'b1;
                  state      <= CALC;
               end
            end
            // adder stage: operands held until the sum has settled
            CALC: begin
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - 1'b1;
               end else begin
                  bus.rsp_data  <= add_sum;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end
            end
            // response stage: pointer advances past the owner only once the result is taken
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  rr_ptr        <= (bus.rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : bus.rsp_id + 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dsp_add_arbiter.sv
// Randomized self-checking bench for dsp_add_arbiter: one ADD_LATENCY=1 instance and one
// ADD_LATENCY=3 instance, checked against a transaction-level round-robin model.
module tb_dsp_add_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        busy0, busy3;
   logic [31:0] adda0, addb0, addsum0;
   logic [31:0] adda3, addb3, addsum3;

   dsp_add_arbiter_if #(.NUM_REQ(4), .ID_W(2)) if0 ();
   dsp_add_arbiter_if #(.NUM_REQ(4), .ID_W(2)) if3 ();

   dsp_add_arbiter #(.NUM_REQ(4), .ID_W(2), .ADD_LATENCY(1)) u_dut0 (
      .clk(clk), .reset(reset), .bus(if0.slave), .busy(busy0),
      .add_a(adda0), .add_b(addb0), .add_sum(addsum0));

   dsp_add_arbiter #(.NUM_REQ(4), .ID_W(2), .ADD_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .bus(if3.slave), .busy(busy3),
      .add_a(adda3), .add_b(addb3), .add_sum(addsum3));

   // Single-cycle adder for the latency-1 instance.
   assign addsum0 = adda0 + addb0;

   // Three-cycle adder: output is unknown until the operands have been stable three cycles.
   logic [31:0] prev_a3, prev_b3;
   int          stab3_q = 0;
   int          stab3;
   always_comb begin
      stab3   = ((adda3 !== prev_a3) || (addb3 !== prev_b3)) ? 1 : stab3_q + 1;
      addsum3 = (stab3 >= 3) ? adda3 + addb3 : 'x;
   end
   always @(posedge clk) begin
      prev_a3 <= adda3;
      prev_b3 <= addb3;
      stab3_q <= stab3;
   end

   logic [31:0] op_a [4];
   logic [31:0] op_b [4];
   always_comb begin
      if0.req_a = '0;
      if0.req_b = '0;
      for (int i = 0; i < 4; i++) begin
         if0.req_a[32*i +: 32] = op_a[i];
         if0.req_b[32*i +: 32] = op_b[i];
      end
   end

   int vectors    = 0;
   int miscompares = 0;
   int model_rr   = 0;

   function automatic int exp_grant(input logic [3:0] m, input int rr);
      logic [1:0] ix;
      for (int k = 0; k < 4; k++) begin
         ix = 2'((rr + k) % 4);
         if (m[ix]) return int'(ix);
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [3:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Drives one transaction on the latency-1 instance from the current inputs.
   task automatic run_op(input bit keep, input int rdy_delay, output int g, output int lat,
                         output logic [31:0] data, output int id);
      int c;
      g = -1; lat = 0; data = '0; id = -1; c = 0;
      #1;
      while (if0.req_ready == 4'b0 && c < 20) begin
         tick(); #1; c++;
      end
      g = onehot_idx(if0.req_ready);
      if (g < 0) return;
      tick();
      if (keep) begin
         op_a[g] = $urandom;
         op_b[g] = $urandom;
      end else begin
         if0.req_valid[2'(g)] = 1'b0;
      end
      lat = 1; #1;
      while (!if0.rsp_valid && lat < 20) begin
         tick(); #1; lat++;
      end
      data = if0.rsp_data;
      id   = int'(if0.rsp_id);
      if (rdy_delay >= 0) begin
         if0.rsp_ready = 1'b0;
         repeat (rdy_delay) tick();
         if0.rsp_ready = 1'b1;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if0.req_valid = 4'b1111; if0.rsp_ready = 1'b1;
      if3.req_valid = 4'b0; if3.req_a = '0; if3.req_b = '0; if3.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin op_a[i] = $urandom; op_b[i] = $urandom; end
      repeat (2) tick();
      #1;
      vectors++;
      if (if0.req_ready !== 4'b0) begin
         miscompares++; $display("FAIL reset_req_ready: got %b want 0000", if0.req_ready);
      end
      vectors++;
      if ({if0.rsp_valid, busy0, if0.rsp_id} !== 4'b0) begin
         miscompares++; $display("FAIL reset_ctrl: got valid=%b busy=%b id=%0d want all 0", if0.rsp_valid, busy0, if0.rsp_id);
      end
      vectors++;
      if ({if0.rsp_data, adda0, addb0} !== 96'b0) begin
         miscompares++; $display("FAIL reset_data: got data=%h a=%h b=%h want 0", if0.rsp_data, adda0, addb0);
      end
      if0.req_valid = 4'b0;
      reset = 1'b0;
      model_rr = 0;
   endtask

   task automatic test_basic();
      tick();
      op_a[0] = 32'h5; op_b[0] = 32'h7; if0.req_valid = 4'b0001;
      #1;
      vectors++;
      if (if0.req_ready !== 4'b0001 || busy0 !== 1'b0) begin
         miscompares++; $display("FAIL basic_grant: got ready=%b busy=%b want 0001 0", if0.req_ready, busy0);
      end
      tick(); if0.req_valid = 4'b0; #1;
      vectors++;
      if ({busy0, if0.rsp_valid} !== 2'b10 || adda0 !== 32'h5 || addb0 !== 32'h7) begin
         miscompares++; $display("FAIL basic_calc: got busy=%b valid=%b a=%h b=%h want 1 0 5 7", busy0, if0.rsp_valid, adda0, addb0);
      end
      tick(); #1;
      vectors++;
      if ({busy0, if0.rsp_valid} !== 2'b11 || if0.rsp_data !== 32'hC || if0.rsp_id !== 2'd0) begin
         miscompares++; $display("FAIL basic_resp: got busy=%b valid=%b data=%h id=%0d want 1 1 c 0", busy0, if0.rsp_valid, if0.rsp_data, if0.rsp_id);
      end
      tick(); #1;
      vectors++;
      if ({busy0, if0.rsp_valid} !== 2'b00) begin
         miscompares++; $display("FAIL basic_done: got busy=%b valid=%b want 0 0", busy0, if0.rsp_valid);
      end
      model_rr = 1;
   endtask

   task automatic test_wrap();
      int r, g, lat, id;
      logic [31:0] d;
      tick();
      r = $urandom_range(0, 3);
      op_a[r] = 32'hFFFF_FFFF; op_b[r] = 32'h0000_0002;
      if0.req_valid = 4'b0001 << r;
      run_op(1'b0, 0, g, lat, d, id);
      vectors++;
      if (g !== r || id !== r || d !== 32'h0000_0001) begin
         miscompares++; $display("FAIL wrap_sum: got g=%0d id=%0d data=%h want %0d %0d 00000001", g, id, d, r, r);
      end
      model_rr = (r + 1) % 4;
   endtask

   task automatic test_round_robin();
      int g, lat, id;
      logic [31:0] d, es;
      reset = 1'b1; tick(); reset = 1'b0; model_rr = 0;
      for (int i = 0; i < 4; i++) begin op_a[i] = $urandom; op_b[i] = $urandom; end
      if0.req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         es = op_a[n % 4] + op_b[n % 4];
         run_op(1'b1, 0, g, lat, d, id);
         vectors++;
         if (g !== n % 4 || id !== n % 4 || d !== es || lat !== 2) begin
            miscompares++; $display("FAIL rr_order[%0d]: got g=%0d id=%0d data=%h lat=%0d want %0d %0d %h 2", n, g, id, d, lat, n % 4, n % 4, es);
         end
      end
      if0.req_valid = 4'b0;
      model_rr = 1;
   endtask

   task automatic test_backpressure();
      int g, lat, id, ex, ex2;
      logic [31:0] d, ea, eb, es;
      logic [3:0] rem;
      tick();
      for (int i = 0; i < 4; i++) begin op_a[i] = $urandom; op_b[i] = $urandom; end
      if0.req_valid = 4'b1111;
      ex = exp_grant(4'b1111, model_rr);
      ea = op_a[ex]; eb = op_b[ex]; es = ea + eb;
      rem = 4'b1111 & ~(4'b0001 << ex);
      if0.rsp_ready = 1'b0;
      run_op(1'b0, -1, g, lat, d, id);
      vectors++;
      if (g !== ex || id !== ex || d !== es) begin
         miscompares++; $display("FAIL bp_first: got g=%0d id=%0d data=%h want %0d %0d %h", g, id, d, ex, ex, es);
      end
      for (int c = 0; c < 5; c++) begin
         tick(); #1;
         vectors++;
         if (if0.rsp_valid !== 1'b1 || if0.rsp_data !== es || int'(if0.rsp_id) !== ex) begin
            miscompares++; $display("FAIL bp_hold_rsp[%0d]: got valid=%b data=%h id=%0d want 1 %h %0d", c, if0.rsp_valid, if0.rsp_data, if0.rsp_id, es, ex);
         end
         vectors++;
         if (if0.req_ready !== 4'b0 || adda0 !== ea || addb0 !== eb) begin
            miscompares++; $display("FAIL bp_hold_req[%0d]: got ready=%b a=%h b=%h want 0000 %h %h", c, if0.req_ready, adda0, addb0, ea, eb);
         end
      end
      if0.rsp_ready = 1'b1;
      tick();
      model_rr = (ex + 1) % 4;
      ex2 = exp_grant(rem, model_rr);
      #1;
      vectors++;
      if (if0.req_ready !== (4'b0001 << ex2) || if0.rsp_valid !== 1'b0) begin
         miscompares++; $display("FAIL bp_next_grant: got ready=%b valid=%b want %b 0", if0.req_ready, if0.rsp_valid, 4'b0001 << ex2);
      end
      if0.req_valid = 4'b0;
   endtask

   task automatic test_random();
      int g, lat, id, ex, dly;
      logic [31:0] d, es;
      logic [3:0] pend, add;
      tick();
      pend = 4'b0;
      for (int n = 0; n < 40; n++) begin
         add = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            if (add[i] && !pend[i]) begin op_a[i] = $urandom; op_b[i] = $urandom; end
         end
         pend = pend | add;
         if (pend == 4'b0) begin
            pend = 4'b0001;
            op_a[0] = $urandom; op_b[0] = $urandom;
         end
         if0.req_valid = pend;
         ex = exp_grant(pend, model_rr);
         es = op_a[ex] + op_b[ex];
         dly = $urandom_range(0, 2);
         run_op(1'b0, dly, g, lat, d, id);
         vectors++;
         if (g !== ex || id !== ex || d !== es || lat !== 2) begin
            miscompares++; $display("FAIL random[%0d]: got g=%0d id=%0d data=%h lat=%0d want %0d %0d %h 2", n, g, id, d, lat, ex, ex, es);
         end
         pend = pend & ~(4'b0001 << ex);
         model_rr = (ex + 1) % 4;
      end
      if0.req_valid = 4'b0;
   endtask

   task automatic test_latency3();
      logic [31:0] a, b;
      logic [3:0] masks [2];
      int ids [2];
      masks[0] = 4'b0010; ids[0] = 1;
      masks[1] = 4'b0001; ids[1] = 0;
      tick();
      for (int t = 0; t < 2; t++) begin
         a = $urandom; b = $urandom;
         if3.req_a = '0; if3.req_b = '0;
         if3.req_a[32*ids[t] +: 32] = a;
         if3.req_b[32*ids[t] +: 32] = b;
         if3.req_valid = masks[t];
         #1;
         vectors++;
         if (if3.req_ready !== masks[t]) begin
            miscompares++; $display("FAIL lat3_grant[%0d]: got %b want %b", t, if3.req_ready, masks[t]);
         end
         tick();
         if3.req_valid = 4'b0; if3.req_a = '1; if3.req_b = '1;
         #1;
         for (int c = 1; c <= 3; c++) begin
            vectors++;
            if (if3.rsp_valid !== 1'b0 || busy3 !== 1'b1) begin
               miscompares++; $display("FAIL lat3_wait[%0d.%0d]: got valid=%b busy=%b want 0 1", t, c, if3.rsp_valid, busy3);
            end
            tick(); #1;
         end
         vectors++;
         if (if3.rsp_valid !== 1'b1 || if3.rsp_data !== a + b || int'(if3.rsp_id) !== ids[t]) begin
            miscompares++; $display("FAIL lat3_resp[%0d]: got valid=%b data=%h id=%0d want 1 %h %0d", t, if3.rsp_valid, if3.rsp_data, if3.rsp_id, a + b, ids[t]);
         end
         tick(); #1;
         vectors++;
         if (if3.rsp_valid !== 1'b0 || busy3 !== 1'b0) begin
            miscompares++; $display("FAIL lat3_done[%0d]: got valid=%b busy=%b want 0 0", t, if3.rsp_valid, busy3);
         end
      end
   endtask

   task automatic test_reset_mid();
      int g, lat, id, ex;
      logic [31:0] d, es;
      tick();
      op_a[2] = $urandom; op_b[2] = $urandom; es = op_a[2] + op_b[2];
      if0.req_valid = 4'b0100;
      run_op(1'b0, 0, g, lat, d, id);
      vectors++;
      if (g !== 2 || d !== es) begin
         miscompares++; $display("FAIL rmid_setup: got g=%0d data=%h want 2 %h", g, d, es);
      end
      model_rr = 3;
      op_a[0] = $urandom; op_b[0] = $urandom;
      if0.req_valid = 4'b0001;
      #1;
      vectors++;
      if (if0.req_ready !== 4'b0001) begin
         miscompares++; $display("FAIL rmid_grant: got %b want 0001", if0.req_ready);
      end
      tick();
      if0.req_valid = 4'b1100;
      op_a[3] = $urandom; op_b[3] = $urandom;
      reset = 1'b1;
      #1;
      vectors++;
      if ({if0.req_ready, if0.rsp_valid, busy0, if0.rsp_id} !== 8'b0 || {if0.rsp_data, adda0, addb0} !== 96'b0) begin
         miscompares++; $display("FAIL rmid_async_clear: got ready=%b valid=%b busy=%b id=%0d data=%h a=%h b=%h want all 0", if0.req_ready, if0.rsp_valid, busy0, if0.rsp_id, if0.rsp_data, adda0, addb0);
      end
      tick();
      reset = 1'b0;
      model_rr = 0;
      ex = exp_grant(4'b1100, model_rr);
      es = op_a[ex] + op_b[ex];
      run_op(1'b0, 0, g, lat, d, id);
      vectors++;
      if (g !== ex || id !== ex || d !== es || lat !== 2) begin
         miscompares++; $display("FAIL rmid_after: got g=%0d id=%0d data=%h lat=%0d want %0d %0d %h 2", g, id, d, lat, ex, ex, es);
      end
      if0.req_valid = 4'b0;
      model_rr = (ex + 1) % 4;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_round_robin();
      test_backpressure();
      test_random();
      test_latency3();
      test_reset_mid();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
